// File: rtl/imem_arbiter_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory arbiter.
//   imem_owner_t  - which requester owns a grant / a pending read response
//   imem_lock_t   - loader exclusive-ownership state
//   IMEM_DEPTH_WORDS - default memory depth in 32-bit words
//   addr_in_range()  - word-granular bounds check of a byte address
package imem_pkg;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_LOADER = 1'b1} imem_owner_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} imem_lock_t;

  localparam int IMEM_DEPTH_WORDS = 1024;

  // Byte address is in range when its word index is below the depth;
  // bits [1:0] never affect the result.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth_words);
    return {2'b00, addr[31:2]} < 32'(depth_words);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch port, the loader port and the shared
// instruction-memory port.
//   slave  - arbiter view: consumes requests and mem_rdata_i, drives
//            ready/rvalid/rdata, the memory strobe/address/data and halt_o.
//   master - environment view (core, loader, memory model): the opposite.
interface imem_arbiter_if;

  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;

  logic        ld_req_i;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic        ld_lock_i;
  logic        ld_ready_o;
  logic        ld_rvalid_o;
  logic [31:0] ld_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic        halt_o;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
    input  mem_rdata_i,
    output fetch_ready_o, fetch_rvalid_o, fetch_rdata_o,
    output ld_ready_o, ld_rvalid_o, ld_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output halt_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
    output mem_rdata_i,
    input  fetch_ready_o, fetch_rvalid_o, fetch_rdata_o,
    input  ld_ready_o, ld_rvalid_o, ld_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  halt_o
  );

endinterface

// File: rtl/imem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   req[1:0]     - request vector (bit 0 = fetch, bit 1 = loader)
//   en           - grant enable; no grant is issued while low
//   gnt[1:0]     - one-hot grant, combinational from req, en and last_q
// On a tie the requester that did not win last time is granted. last_q
// resets to the loader so the fetch side wins the first tie.
module rr_arbiter2
  import imem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  imem_owner_t last_q;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == OWN_LOADER) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_LOADER;
    end else if (gnt[0]) begin
      last_q <= OWN_FETCH;
    end else if (gnt[1]) begin
      last_q <= OWN_LOADER;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous-read instruction-memory port between
// the core fetch stage and the program loader.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   bus (slave)  - fetch port, loader port, memory port and halt_o
// Parameter DEPTH_WORDS sets the memory depth in 32-bit words. Accesses above
// the last byte address are accepted but never reach memory; such reads
// answer with zero data on the normal rvalid timing.
// The loader may request a lock: the core is halted at once, and ownership
// becomes exclusive after any fetch read issued in the previous cycle drains.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
  input  logic           clk_i,
  input  logic           rst_i,
  imem_arbiter_if.slave  bus
);

  imem_lock_t  lock_q, lock_d;
  logic [1:0]  arb_req, gnt;
  logic        any_gnt, win_we, in_range, rd_accept;
  logic [31:0] win_addr, win_wdata, rsp_data;
  logic        rvalid_q, oor_q;
  imem_owner_t owner_q;
  logic        fetch_inflight;

  // A fetch read accepted last cycle is still waiting for its rvalid.
  assign fetch_inflight = rvalid_q && (owner_q == OWN_FETCH);

  // Lock FSM: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= UNLOCKED;
    else       lock_q <= lock_d;
  end

  // Lock FSM: next state and arbiter request masking. While a lock is
  // pending the fetch stays grantable so its read can drain.
  always_comb begin
    lock_d  = lock_q;
    arb_req = {bus.ld_req_i, bus.fetch_req_i};
    case (lock_q)
      UNLOCKED: if (bus.ld_lock_i && !fetch_inflight) lock_d = LOCKED;
      LOCKED: begin
        arb_req = {bus.ld_req_i, 1'b0};
        if (!bus.ld_lock_i) lock_d = UNLOCKED;
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  assign bus.halt_o = (lock_q == LOCKED) || bus.ld_lock_i;

  rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (arb_req),
    .en    (!rst_i),
    .gnt   (gnt)
  );

  assign bus.fetch_ready_o = gnt[0];
  assign bus.ld_ready_o    = gnt[1];
  assign any_gnt           = |gnt;

  // Winner mux; the fetch side can only read.
  always_comb begin
    win_addr  = 32'h0;
    win_we    = 1'b0;
    win_wdata = 32'h0;
    if (gnt[0]) begin
      win_addr = bus.fetch_addr_i & ~32'h3;
    end else if (gnt[1]) begin
      win_addr  = bus.ld_addr_i & ~32'h3;
      win_we    = bus.ld_we_i;
      win_wdata = bus.ld_wdata_i;
    end
  end

  assign in_range        = addr_in_range(win_addr, DEPTH_WORDS);
  assign bus.mem_req_o   = any_gnt && in_range;
  assign bus.mem_we_o    = win_we;
  assign bus.mem_addr_o  = win_addr;
  assign bus.mem_wdata_o = win_wdata;
  assign rd_accept       = any_gnt && !win_we;

  // Response pipeline: one stage matching the memory's read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      owner_q  <= OWN_FETCH;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_accept;
      owner_q  <= gnt[1] ? OWN_LOADER : OWN_FETCH;
      oor_q    <= !in_range;
    end
  end

  assign rsp_data           = oor_q ? 32'h0 : bus.mem_rdata_i;
  assign bus.fetch_rvalid_o = rvalid_q && (owner_q == OWN_FETCH);
  assign bus.ld_rvalid_o    = rvalid_q && (owner_q == OWN_LOADER);
  assign bus.fetch_rdata_o  = bus.fetch_rvalid_o ? rsp_data : 32'h0;
  assign bus.ld_rdata_o     = bus.ld_rvalid_o ? rsp_data : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vector table, hand-written lock/reset sequences
// and randomized traffic checked against a transaction-level model.
module tb_imem_arbiter;

  localparam int  DEPTH = 1024;
  localparam bit  H = 1'b1;
  localparam bit  L = 1'b0;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic mem_fill = 1'b1;

  always #5 clk_i = ~clk_i;

  imem_arbiter_if bus ();

  imem_arbiter #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] mw(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Environment memory: synchronous read, write on the strobe edge.
  logic [31:0] tb_mem [DEPTH];
  always @(posedge clk_i) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= mw(i);
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) tb_mem[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i <= tb_mem[bus.mem_addr_o[11:2]];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [DEPTH];
  bit          m_locked, m_last_loader, m_pend_valid, m_pend_loader, m_prev_fetch_rd;
  logic [31:0] m_pend_data;
  bit          cmp_en = 1'b0;

  task automatic model_step(input bit rst, input bit freq, input logic [31:0] faddr,
                            input bit lreq, input bit lwe, input logic [31:0] laddr,
                            input logic [31:0] lwdata, input bit lock);
    bit win, win_ld, wr, inr, new_lock;
    logic [31:0] addr, word;
    if (rst) begin
      m_locked = 0; m_last_loader = 1; m_pend_valid = 0; m_prev_fetch_rd = 0;
    end
    win = 0; win_ld = 0;
    if (!rst) begin
      if (m_locked)          begin win = lreq; win_ld = 1; end
      else if (freq && lreq) begin win = 1; win_ld = !m_last_loader; end
      else if (freq)         begin win = 1; win_ld = 0; end
      else if (lreq)         begin win = 1; win_ld = 1; end
    end
    addr = win_ld ? laddr : faddr;
    word = addr >> 2;
    inr  = word < DEPTH;
    wr   = win && win_ld && lwe;
    if (cmp_en) begin
      check("rnd fready", bus.fetch_ready_o, win && !win_ld);
      check("rnd ldready", bus.ld_ready_o, win && win_ld);
      check("rnd memreq", bus.mem_req_o, win && inr);
      check("rnd halt", bus.halt_o, m_locked || lock);
      check("rnd frvalid", bus.fetch_rvalid_o, m_pend_valid && !m_pend_loader);
      check("rnd lrvalid", bus.ld_rvalid_o, m_pend_valid && m_pend_loader);
      check("rnd frdata", bus.fetch_rdata_o, (m_pend_valid && !m_pend_loader) ? m_pend_data : 32'h0);
      check("rnd lrdata", bus.ld_rdata_o, (m_pend_valid && m_pend_loader) ? m_pend_data : 32'h0);
      if (win) begin
        check("rnd memaddr", bus.mem_addr_o, word << 2);
        check("rnd memwe", bus.mem_we_o, wr);
      end
      if (wr && inr) check("rnd memwdata", bus.mem_wdata_o, lwdata);
    end
    if (!rst) begin
      new_lock = m_locked ? lock : (lock && !m_prev_fetch_rd);
      if (win) m_last_loader = win_ld;
      if (wr && inr) ref_mem[word] = lwdata;
      m_pend_valid    = win && !wr;
      m_pend_loader   = win_ld;
      m_pend_data     = inr ? ref_mem[word] : 32'h0;
      m_prev_fetch_rd = m_pend_valid && !win_ld;
      m_locked        = new_lock;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let the model track it.
  task automatic apply(input bit rst, input bit freq, input logic [31:0] faddr,
                       input bit lreq, input bit lwe, input logic [31:0] laddr,
                       input logic [31:0] lwdata, input bit lock);
    @(negedge clk_i);
    rst_i            = rst;
    bus.fetch_req_i  = freq;
    bus.fetch_addr_i = faddr;
    bus.ld_req_i     = lreq;
    bus.ld_we_i      = lwe;
    bus.ld_addr_i    = laddr;
    bus.ld_wdata_i   = lwdata;
    bus.ld_lock_i    = lock;
    #1;
    model_step(rst, freq, faddr, lreq, lwe, laddr, lwdata, lock);
  endtask

  task automatic idle();
    apply(L, L, 32'h0, L, L, 32'h0, 32'h0, L);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return 32'h1000 + ($urandom & 32'hFFFF);
    else if (r == 1) return 32'hFFC + 32'($urandom_range(0, 3));
    else             return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    bit freq; logic [31:0] faddr; bit lreq; bit lwe; logic [31:0] laddr;
    logic [31:0] lwdata; bit lock;
    bit e_fr; bit e_lr; bit e_mreq; bit e_mwe; logic [31:0] e_maddr; bit e_halt;
    bit e_frv; bit e_lrv; logic [31:0] e_frd; logic [31:0] e_lrd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    bit lock_state;
    bus.fetch_req_i = 0; bus.fetch_addr_i = 0; bus.ld_req_i = 0; bus.ld_we_i = 0;
    bus.ld_addr_i = 0; bus.ld_wdata_i = 0; bus.ld_lock_i = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mw(i);

    // Reset state (ld_lock high to see halt follow it).
    apply(H, H, 32'h0, H, L, 32'h4, 32'h0, H);
    check("rst fready", bus.fetch_ready_o, 1'b0);
    check("rst ldready", bus.ld_ready_o, 1'b0);
    check("rst frvalid", bus.fetch_rvalid_o, 1'b0);
    check("rst lrvalid", bus.ld_rvalid_o, 1'b0);
    check("rst frdata", bus.fetch_rdata_o, 32'h0);
    check("rst lrdata", bus.ld_rdata_o, 32'h0);
    check("rst halt", bus.halt_o, 1'b1);
    check("rst memreq", bus.mem_req_o, 1'b0);
    apply(H, L, 32'h0, L, L, 32'h0, 32'h0, L);
    check("rst halt low", bus.halt_o, 1'b0);
    @(negedge clk_i);
    mem_fill = 1'b0;

    //            freq faddr        lreq lwe laddr        lwdata        lock  fr lr mreq mwe maddr        halt frv lrv frd           lrd
    vecs[0]  = '{H, 32'h0,    L, L, 32'h0,    32'h0,        L,  H, L, H, L, 32'h0,    L, L, L, 32'h0,        32'h0};
    vecs[1]  = '{H, 32'h4,    L, L, 32'h0,    32'h0,        L,  H, L, H, L, 32'h4,    L, H, L, mw(0),        32'h0};
    vecs[2]  = '{H, 32'h8,    L, L, 32'h0,    32'h0,        L,  H, L, H, L, 32'h8,    L, H, L, mw(1),        32'h0};
    vecs[3]  = '{L, 32'h0,    L, L, 32'h0,    32'h0,        L,  L, L, L, L, 32'h0,    L, H, L, mw(2),        32'h0};
    vecs[4]  = '{H, 32'h0,    H, L, 32'hC,    32'h0,        L,  L, H, H, L, 32'hC,    L, L, L, 32'h0,        32'h0};
    vecs[5]  = '{H, 32'h4,    H, L, 32'h8,    32'h0,        L,  H, L, H, L, 32'h4,    L, L, H, 32'h0,        mw(3)};
    vecs[6]  = '{H, 32'h8,    H, L, 32'h0,    32'h0,        L,  L, H, H, L, 32'h0,    L, H, L, mw(1),        32'h0};
    vecs[7]  = '{H, 32'hC,    H, L, 32'h4,    32'h0,        L,  H, L, H, L, 32'hC,    L, L, H, 32'h0,        mw(0)};
    vecs[8]  = '{L, 32'h0,    H, H, 32'h10,   32'hDEADBEEF, L,  L, H, H, H, 32'h10,   L, H, L, mw(3),        32'h0};
    vecs[9]  = '{H, 32'h10,   L, L, 32'h0,    32'h0,        L,  H, L, H, L, 32'h10,   L, L, L, 32'h0,        32'h0};
    vecs[10] = '{L, 32'h0,    L, L, 32'h0,    32'h0,        L,  L, L, L, L, 32'h0,    L, H, L, 32'hDEADBEEF, 32'h0};
    vecs[11] = '{H, 32'h1000, L, L, 32'h0,    32'h0,        L,  H, L, L, L, 32'h1000, L, L, L, 32'h0,        32'h0};
    vecs[12] = '{L, 32'h0,    H, H, 32'h1000, 32'h12345678, L,  L, H, L, H, 32'h1000, L, H, L, 32'h0,        32'h0};
    vecs[13] = '{L, 32'h0,    H, L, 32'h0,    32'h0,        L,  L, H, H, L, 32'h0,    L, L, L, 32'h0,        32'h0};
    vecs[14] = '{L, 32'h0,    L, L, 32'h0,    32'h0,        L,  L, L, L, L, 32'h0,    L, L, H, 32'h0,        mw(0)};
    vecs[15] = '{H, 32'h13,   L, L, 32'h0,    32'h0,        L,  H, L, H, L, 32'h10,   L, L, L, 32'h0,        32'h0};
    vecs[16] = '{L, 32'h0,    H, L, 32'hFFF,  32'h0,        L,  L, H, H, L, 32'hFFC,  L, H, L, 32'hDEADBEEF, 32'h0};
    vecs[17] = '{L, 32'h0,    L, L, 32'h0,    32'h0,        L,  L, L, L, L, 32'h0,    L, L, H, 32'h0,        mw(1023)};

    for (int i = 0; i < 18; i++) begin
      apply(L, vecs[i].freq, vecs[i].faddr, vecs[i].lreq, vecs[i].lwe, vecs[i].laddr,
            vecs[i].lwdata, vecs[i].lock);
      check($sformatf("v%0d fready", i), bus.fetch_ready_o, vecs[i].e_fr);
      check($sformatf("v%0d ldready", i), bus.ld_ready_o, vecs[i].e_lr);
      check($sformatf("v%0d memreq", i), bus.mem_req_o, vecs[i].e_mreq);
      check($sformatf("v%0d memwe", i), bus.mem_we_o, vecs[i].e_mwe);
      check($sformatf("v%0d memaddr", i), bus.mem_addr_o, vecs[i].e_maddr);
      check($sformatf("v%0d halt", i), bus.halt_o, vecs[i].e_halt);
      check($sformatf("v%0d frvalid", i), bus.fetch_rvalid_o, vecs[i].e_frv);
      check($sformatf("v%0d lrvalid", i), bus.ld_rvalid_o, vecs[i].e_lrv);
      check($sformatf("v%0d frdata", i), bus.fetch_rdata_o, vecs[i].e_frd);
      check($sformatf("v%0d lrdata", i), bus.ld_rdata_o, vecs[i].e_lrd);
    end

    // Lock raised while a fetch read is in flight.
    apply(L, H, 32'h8, L, L, 32'h0, 32'h0, L);
    check("lk0 fready", bus.fetch_ready_o, 1'b1);
    apply(L, L, 32'h0, L, L, 32'h0, 32'h0, H);
    check("lk1 halt", bus.halt_o, 1'b1);
    check("lk1 frvalid", bus.fetch_rvalid_o, 1'b1);
    check("lk1 frdata", bus.fetch_rdata_o, mw(2));
    apply(L, L, 32'h0, L, L, 32'h0, 32'h0, H);
    check("lk2 halt", bus.halt_o, 1'b1);
    check("lk2 frvalid", bus.fetch_rvalid_o, 1'b0);
    apply(L, H, 32'hC, H, L, 32'h10, 32'h0, H);
    check("lk3 fready", bus.fetch_ready_o, 1'b0);
    check("lk3 ldready", bus.ld_ready_o, 1'b1);
    check("lk3 memaddr", bus.mem_addr_o, 32'h10);
    apply(L, H, 32'hC, H, H, 32'h20, 32'hCAFEF00D, H);
    check("lk4 fready", bus.fetch_ready_o, 1'b0);
    check("lk4 memwe", bus.mem_we_o, 1'b1);
    check("lk4 lrvalid", bus.ld_rvalid_o, 1'b1);
    check("lk4 lrdata", bus.ld_rdata_o, 32'hDEADBEEF);
    apply(L, H, 32'hC, L, L, 32'h0, 32'h0, L);
    check("lk5 fready", bus.fetch_ready_o, 1'b0);
    check("lk5 halt", bus.halt_o, 1'b1);
    apply(L, H, 32'h20, L, L, 32'h0, 32'h0, L);
    check("lk6 fready", bus.fetch_ready_o, 1'b1);
    check("lk6 halt", bus.halt_o, 1'b0);
    idle();
    check("lk7 frvalid", bus.fetch_rvalid_o, 1'b1);
    check("lk7 frdata", bus.fetch_rdata_o, 32'hCAFEF00D);

    // Reset pulse between a read accept and its rvalid.
    apply(L, H, 32'h4, L, L, 32'h0, 32'h0, L);
    check("rp0 fready", bus.fetch_ready_o, 1'b1);
    apply(H, H, 32'h8, H, L, 32'hC, 32'h0, H);
    check("rp1 frvalid", bus.fetch_rvalid_o, 1'b0);
    check("rp1 frdata", bus.fetch_rdata_o, 32'h0);
    check("rp1 fready", bus.fetch_ready_o, 1'b0);
    check("rp1 ldready", bus.ld_ready_o, 1'b0);
    check("rp1 memreq", bus.mem_req_o, 1'b0);
    check("rp1 halt", bus.halt_o, 1'b1);
    apply(L, H, 32'h8, H, L, 32'hC, 32'h0, L);
    check("rp2 frvalid", bus.fetch_rvalid_o, 1'b0);
    check("rp2 lrvalid", bus.ld_rvalid_o, 1'b0);
    check("rp2 fready", bus.fetch_ready_o, 1'b1);
    check("rp2 ldready", bus.ld_ready_o, 1'b0);
    check("rp2 halt", bus.halt_o, 1'b0);
    idle();
    check("rp3 frvalid", bus.fetch_rvalid_o, 1'b1);
    check("rp3 frdata", bus.fetch_rdata_o, mw(2));

    // Randomized traffic against the model.
    cmp_en = 1'b1;
    lock_state = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) lock_state = !lock_state;
      apply(($urandom_range(0, 499) == 0) ? H : L,
            1'($urandom_range(0, 1)), rand_addr(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3) ? H : L, rand_addr(),
            $urandom, lock_state);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Shares the single instruction-memory port between the core fetch stage and the program loader (debug/UART boot path).
- Arbitrates per cycle and drives the memory port (synchronous read, 1-cycle latency).
- Steers read data back to the winning requester.
- Provides a lock so the loader can own memory exclusively during a bulk program load, with the core held in stall.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory depth in 32-bit words; byte address limit is DEPTH_WORDS*4-1.

Ports:
- clk_i  in  1  single system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- fetch_req_i  in  1  fetch read request.
- fetch_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- fetch_ready_o  out  1  fetch request accepted this cycle.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  32  fetch read data.
- ld_req_i  in  1  loader request.
- ld_we_i  in  1  loader write enable: 1 = write, 0 = read.
- ld_addr_i  in  32  loader byte address; bits [1:0] ignored.
- ld_wdata_i  in  32  loader write data.
- ld_lock_i  in  1  loader exclusive-ownership request.
- ld_ready_o  out  1  loader request accepted.
- ld_rvalid_o  out  1  loader read data valid.
- ld_rdata_o  out  32  loader read data.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory byte address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid one cycle after mem_req_o with mem_we_o=0.
- halt_o  out  1  core stall; high while the lock is held.

## Operation
- State machine `lock_q`: UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED when ld_lock_i=1 and no fetch read is in flight, i.e. the `rvalid` pipeline holds no fetch read issued in the previous cycle.
  - LOCKED -> UNLOCKED when ld_lock_i=0.
- halt_o = (lock_q==LOCKED) or (ld_lock_i=1).
- In LOCKED:
  - fetch_ready_o=0.
  - ld_ready_o=ld_req_i.
- In UNLOCKED:
  - If only one requester is active, that requester is granted.
  - If both are active, grant goes to the one not in `last_q`. This is round-robin.
  - `last_q` updates on every grant.
  - While ld_lock_i=1 and lock is pending, the fetch is still grantable so its in-flight read can drain.
- A grant is combinational: req_i & ready_o marks the accept cycle, and mem_req_o is asserted in that same cycle.
- mem_addr_o, mem_we_o and mem_wdata_o come from the winner. The fetch winner always has mem_we_o=0.
- Range check: an address above DEPTH_WORDS*4-1 is accepted but out of range.
  - It gives mem_req_o=0.
  - A read returns rdata=0 with the normal rvalid timing.
  - A write is dropped silently.
- Each read accept registers an owner tag and an `oor` flag.
- In the next cycle:
  - Exactly one rvalid is asserted.
  - The matching rdata is mem_rdata_i, or 0 if `oor` is set.
  - The other requester's rdata is 0.
- A write accept produces no rvalid.
- The block is fully pipelined: one accept per cycle, and back-to-back reads give back-to-back rvalid.

## Timing
- Reset values:
  - fetch_rvalid_o=0, ld_rvalid_o=0.
  - Both rdata outputs = 0.
  - halt_o follows ld_lock_i.
  - lock_q=UNLOCKED.
  - last_q=LOADER, so fetch wins the first tie.
- ready outputs are combinational from req, lock and last_q. They are 0 while rst_i=1.
- Read latency: rvalid occurs exactly 1 cycle after accept.
- Write: takes effect at the memory on the accept edge.
- Simultaneous requests plus a lock request: a fetch already granted in that cycle completes, and LOCKED is entered the following cycle.
- Reset asserted mid-transfer: the pending rvalid is discarded and never presented. The lock is released.

## Structure
- Package imem_pkg holds:
  - `typedef enum logic {OWN_FETCH, OWN_LOADER} imem_owner_t`.
  - `typedef enum logic {UNLOCKED, LOCKED} imem_lock_t`.
  - Constant IMEM_DEPTH_WORDS = 1024.
- One sub-module: rr_arbiter2.
  - Two-input round-robin arbiter with its `last_q` register.
  - Inputs: req[1:0], en.
  - Output: one-hot gnt.
- The top level contains the lock FSM, range check and response steering.

## Test plan
- Fetch-only reads at 0x0, 0x4, 0x8 on consecutive cycles -> fetch_ready_o high every cycle. fetch_rvalid_o high on cycles 1-3 with the memory words; mem_we_o=0 throughout.
- Both requesters held high for 4 cycles -> grants alternate fetch, loader, fetch, loader. Each rvalid goes only to its own owner.
- Loader writes 0xDEADBEEF to 0x10, then fetch reads 0x10 -> fetch_rdata_o=0xDEADBEEF one cycle after the fetch accept.
- Fetch read at 0x1000 (>4095) -> mem_req_o=0, fetch_rvalid_o=1 the next cycle, fetch_rdata_o=0. A loader write to 0x1000 leaves memory unchanged.
- ld_lock_i raised while a fetch is in flight:
  - halt_o goes high immediately.
  - The fetch rvalid completes.
  - From then on fetch_ready_o=0 until ld_lock_i falls, after which fetch is granted the next cycle.
- rst_i pulsed for one cycle between a read accept and its rvalid -> no rvalid is seen. All outputs hold their reset values, and last_q reverts so fetch wins the next tie.
